// File: rtl/down_counter_if.sv
// Load handshake, control and status bundle for down_counter.
interface down_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output clear, load_valid, load_value, enable,
        input  load_ready, count, busy, done, tc
    );

    modport slave (
        input  clear, load_valid, load_value, enable,
        output load_ready, count, busy, done, tc
    );
endinterface

// File: rtl/down_counter.sv
// Loadable down-counter/timer with terminal-count pulse.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload from the last loaded value instead of stopping.
module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    down_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tc_q     <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.clear) begin
            // Abort leaves the reload value intact for a later restart.
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.load_valid) begin
                        count_d  = bus.load_value;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                        reload_d = bus.load_value;
`endif
                        if (bus.load_value == '0) begin
                            state_d = DONE;
                            tc_d    = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (count_q == WIDTH'(1)) begin
                            tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = DONE;
`endif
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign bus.count      = count_q;
    assign bus.tc         = tc_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.load_ready = (state_q != RUN);
endmodule
